// File: rtl/pspin_hostmem_dma_wr.sv
`default_nettype none
// ============================================================================
//  Module      : pspin_hostmem_dma_wr
//  Description : AXI4 write slave that forwards one INCR burst to a client
//                stream, then issues a host DMA write and returns B.
//  Revision    : 1.0 - initial release
// ============================================================================
module pspin_hostmem_dma_wr #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 512,
    parameter int STRB_WIDTH     = DATA_WIDTH/8,
    parameter int ID_WIDTH       = 8,
    parameter int DMA_LEN_WIDTH  = 16,
    parameter int DMA_TAG_WIDTH  = 16,
    parameter int RAM_SEL_WIDTH  = 4,
    parameter int RAM_ADDR_WIDTH = 20
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [ID_WIDTH-1:0]       s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,

    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [STRB_WIDTH-1:0]     s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,

    output logic [ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,

    output logic [RAM_ADDR_WIDTH-1:0] m_axis_client_desc_ram_addr,
    output logic [DMA_LEN_WIDTH-1:0]  m_axis_client_desc_len,
    output logic                      m_axis_client_desc_valid,
    input  logic                      m_axis_client_desc_ready,

    input  logic [3:0]                s_axis_client_status_error,
    input  logic                      s_axis_client_status_valid,

    output logic [DATA_WIDTH-1:0]     m_axis_wr_data_tdata,
    output logic [STRB_WIDTH-1:0]     m_axis_wr_data_tkeep,
    output logic                      m_axis_wr_data_tlast,
    output logic                      m_axis_wr_data_tvalid,
    input  logic                      m_axis_wr_data_tready,

    output logic [ADDR_WIDTH-1:0]     m_axis_write_desc_dma_addr,
    output logic [RAM_SEL_WIDTH-1:0]  m_axis_write_desc_ram_sel,
    output logic [RAM_ADDR_WIDTH-1:0] m_axis_write_desc_ram_addr,
    output logic [DMA_LEN_WIDTH-1:0]  m_axis_write_desc_len,
    output logic [DMA_TAG_WIDTH-1:0]  m_axis_write_desc_tag,
    output logic                      m_axis_write_desc_valid,
    input  logic                      m_axis_write_desc_ready,

    input  logic [DMA_TAG_WIDTH-1:0]  s_axis_write_desc_status_tag,
    input  logic [3:0]                s_axis_write_desc_status_error,
    input  logic                      s_axis_write_desc_status_valid
);

    localparam int              c_beat_shift = $clog2(STRB_WIDTH);
    localparam logic [2:0]      c_full_size  = 3'(c_beat_shift);
    localparam logic [1:0]      c_burst_incr = 2'b01;
    localparam logic [1:0]      c_resp_okay  = 2'b00;
    localparam logic [1:0]      c_resp_slv   = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] c_addr_mask = ~(ADDR_WIDTH'(STRB_WIDTH - 1));

    generate
        if (DMA_LEN_WIDTH < 9 + c_beat_shift) begin : g_len_width_check
            $error("DMA_LEN_WIDTH cannot hold a 256-beat burst length");
        end
        if (DMA_TAG_WIDTH < ID_WIDTH) begin : g_tag_width_check
            $error("DMA_TAG_WIDTH narrower than ID_WIDTH");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_ISSUE_CLIENT = 3'd1,
        S_STREAM       = 3'd2,
        S_WAIT_CLIENT  = 3'd3,
        S_ISSUE_DMA    = 3'd4,
        S_WAIT_DMA     = 3'd5,
        S_DRAIN        = 3'd6,
        S_RESP         = 3'd7
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ID_WIDTH-1:0]     r_awid;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [7:0]              r_awlen;
    logic [7:0]              r_beat_cnt;
    logic                    r_err;
    logic [1:0]              r_bresp;

    logic                    w_supported;
    logic                    w_last_beat;
    logic                    w_beat_hs;
    logic                    w_client_err;
    logic                    w_tag_match;
    logic [DMA_LEN_WIDTH-1:0] w_len;
    logic [DMA_TAG_WIDTH-1:0] w_tag;

    assign w_supported  = (s_axi_awburst == c_burst_incr) && (s_axi_awsize == c_full_size);
    assign w_last_beat  = (r_beat_cnt == r_awlen);
    assign w_beat_hs    = s_axi_wvalid && m_axis_wr_data_tready;
    assign w_client_err = (s_axis_client_status_error != 4'd0);
    assign w_len        = (DMA_LEN_WIDTH'(r_awlen) + DMA_LEN_WIDTH'(1)) << c_beat_shift;
    assign w_tag        = DMA_TAG_WIDTH'(r_awid);
    assign w_tag_match  = (s_axis_write_desc_status_tag == w_tag);

    // Descriptor and response fields read as zero whenever their valid is low.
    assign m_axis_client_desc_ram_addr = '0;
    assign m_axis_client_desc_len      = (r_state == S_ISSUE_CLIENT) ? w_len : '0;
    assign m_axis_write_desc_dma_addr  = (r_state == S_ISSUE_DMA) ? (r_awaddr & c_addr_mask) : '0;
    assign m_axis_write_desc_ram_sel   = '0;
    assign m_axis_write_desc_ram_addr  = '0;
    assign m_axis_write_desc_len       = (r_state == S_ISSUE_DMA) ? w_len : '0;
    assign m_axis_write_desc_tag       = (r_state == S_ISSUE_DMA) ? w_tag : '0;
    assign s_axi_bid                   = (r_state == S_RESP) ? r_awid : '0;
    assign s_axi_bresp                 = (r_state == S_RESP) ? r_bresp : c_resp_okay;

    always_comb begin
        w_state_next             = r_state;
        s_axi_awready            = 1'b0;
        s_axi_wready             = 1'b0;
        s_axi_bvalid             = 1'b0;
        m_axis_client_desc_valid = 1'b0;
        m_axis_write_desc_valid  = 1'b0;
        m_axis_wr_data_tvalid    = 1'b0;
        m_axis_wr_data_tdata     = '0;
        m_axis_wr_data_tkeep     = '0;
        m_axis_wr_data_tlast     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Never advertise acceptance while reset is being applied.
                s_axi_awready = ~rst;
                if (s_axi_awvalid) begin
                    w_state_next = w_supported ? S_ISSUE_CLIENT : S_DRAIN;
                end
            end
            S_ISSUE_CLIENT: begin
                m_axis_client_desc_valid = 1'b1;
                if (m_axis_client_desc_ready) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                m_axis_wr_data_tvalid = s_axi_wvalid;
                s_axi_wready          = m_axis_wr_data_tready;
                m_axis_wr_data_tdata  = s_axi_wdata;
                m_axis_wr_data_tkeep  = '1;
                m_axis_wr_data_tlast  = w_last_beat;
                if (w_beat_hs && w_last_beat) begin
                    w_state_next = S_WAIT_CLIENT;
                end
            end
            S_WAIT_CLIENT: begin
                if (s_axis_client_status_valid) begin
                    w_state_next = (r_err || w_client_err) ? S_RESP : S_ISSUE_DMA;
                end
            end
            S_ISSUE_DMA: begin
                m_axis_write_desc_valid = 1'b1;
                if (m_axis_write_desc_ready) begin
                    w_state_next = S_WAIT_DMA;
                end
            end
            S_WAIT_DMA: begin
                if (s_axis_write_desc_status_valid && w_tag_match) begin
                    w_state_next = S_RESP;
                end
            end
            S_DRAIN: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && s_axi_wlast) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_awid     <= '0;
            r_awaddr   <= '0;
            r_awlen    <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            r_bresp    <= c_resp_okay;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (s_axi_awvalid) begin
                        r_awid     <= s_axi_awid;
                        r_awaddr   <= s_axi_awaddr;
                        r_awlen    <= s_axi_awlen;
                        r_beat_cnt <= '0;
                        r_err      <= 1'b0;
                        r_bresp    <= c_resp_okay;
                    end
                end
                S_STREAM: begin
                    if (w_beat_hs) begin
                        r_beat_cnt <= w_last_beat ? 8'd0 : r_beat_cnt + 8'd1;
                        // Partial strobes or a misplaced wlast poison the burst
                        // but the stream is still carried to its natural end.
                        if ((s_axi_wstrb != '1) || (s_axi_wlast != w_last_beat)) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WAIT_CLIENT: begin
                    if (s_axis_client_status_valid) begin
                        if (w_client_err) begin
                            r_err <= 1'b1;
                        end
                        if (r_err || w_client_err) begin
                            r_bresp <= c_resp_slv;
                        end
                    end
                end
                S_WAIT_DMA: begin
                    if (s_axis_write_desc_status_valid && w_tag_match) begin
                        r_bresp <= (s_axis_write_desc_status_error != 4'd0) ? c_resp_slv : c_resp_okay;
                    end
                end
                S_DRAIN: r_bresp <= c_resp_slv;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/pspin_hostmem_dma_wr.md
PSPIN_HOSTMEM_DMA_WR -- requirements
Module: pspin_hostmem_dma_wr

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH 64 host address; DATA_WIDTH 512 AXI/AXIS data; STRB_WIDTH DATA_WIDTH/8 byte lanes; ID_WIDTH 8 AXI ID; DMA_LEN_WIDTH 16 DMA byte length; DMA_TAG_WIDTH 16 DMA tag; RAM_SEL_WIDTH 4; RAM_ADDR_WIDTH 20.
REQ-002 The block has one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1, the block's only clock.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 AW ports: s_axi_awid in ID_WIDTH; s_axi_awaddr in ADDR_WIDTH; s_axi_awlen in 8; s_axi_awsize in 3; s_axi_awburst in 2; s_axi_awvalid in 1; s_axi_awready out 1.
REQ-006 W ports: s_axi_wdata in DATA_WIDTH; s_axi_wstrb in STRB_WIDTH; s_axi_wlast in 1; s_axi_wvalid in 1; s_axi_wready out 1.
REQ-007 B ports: s_axi_bid out ID_WIDTH; s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1.
REQ-008 Client descriptor: m_axis_client_desc_ram_addr out RAM_ADDR_WIDTH; _len out DMA_LEN_WIDTH; _valid out 1; _ready in 1. Client status: s_axis_client_status_error in 4; _valid in 1.
REQ-009 Client data: m_axis_wr_data_tdata out DATA_WIDTH; _tkeep out STRB_WIDTH; _tlast out 1; _tvalid out 1; _tready in 1.
REQ-010 Host DMA write descriptor: m_axis_write_desc_dma_addr out ADDR_WIDTH; _ram_sel out RAM_SEL_WIDTH; _ram_addr out RAM_ADDR_WIDTH; _len out DMA_LEN_WIDTH; _tag out DMA_TAG_WIDTH; _valid out 1; _ready in 1. Host status: s_axis_write_desc_status_tag in DMA_TAG_WIDTH; _error in 4; _valid in 1.

Function
REQ-011 One burst in flight; states IDLE, ISSUE_CLIENT, STREAM, WAIT_CLIENT, ISSUE_DMA, WAIT_DMA, DRAIN, RESP.
REQ-012 IDLE: awready=1; AW handshake latches awid, awaddr, awlen, clears err flag; awready=0 in every other state.
REQ-013 Supported burst: awburst=INCR(01) and awsize=log2(STRB_WIDTH); otherwise IDLE->DRAIN.
REQ-014 len = (awlen+1)*STRB_WIDTH in DMA_LEN_WIDTH bits; dma_addr = awaddr with low log2(STRB_WIDTH) bits cleared; elaboration error if DMA_LEN_WIDTH < 9+log2(STRB_WIDTH) or DMA_TAG_WIDTH < ID_WIDTH.
REQ-015 ISSUE_CLIENT: client desc valid=1, ram_addr=0, len per REQ-014; held until ready, then ->STREAM next cycle.
REQ-016 STREAM: combinational pass-through; tvalid=wvalid, wready=tready, tdata=wdata, tkeep=all-ones, tlast=(beat_cnt==awlen); zero bubbles required.
REQ-017 Any beat with wstrb != all-ones, or wlast != internal tlast, sets err; stream still completes awlen+1 beats.
REQ-018 Last beat handshake ->WAIT_CLIENT; client status valid with error!=0 sets err; then err ? RESP(SLVERR) : ISSUE_DMA.
REQ-019 ISSUE_DMA: write desc valid=1, ram_sel=0, ram_addr=0, len, tag=zero-extended awid; on ready ->WAIT_DMA.
REQ-020 WAIT_DMA: status valid with tag==issued tag -> RESP, bresp=OKAY(00) if error==0 else SLVERR(10); non-matching tags ignored.
REQ-021 DRAIN: wready=1, tvalid=0, beats discarded until wvalid&wready&wlast -> RESP SLVERR.
REQ-022 RESP: bvalid=1, bid=latched awid; held stable until bready; then IDLE, awready=1 next cycle.
REQ-023 Descriptor valids deassert the cycle after handshake; descriptor fields stable while valid.
REQ-024 Status pulses arriving outside their wait state are ignored.

Reset
REQ-025 On rst: state IDLE, err=0, beat_cnt=0; all valid outputs, wready, bresp, bid, tlast, descriptor fields = 0; awready=1 from first cycle after rst deasserts.
REQ-026 rst mid-burst aborts silently: no B response, no descriptor reissue.

Verification
REQ-027 AW id=0x5, addr=0x1000_0040, len=3, size=6, INCR; 4 full beats -> client len=256, DMA dma_addr=0x1000_0040 len=256 tag=0x5, status OK -> bid=0x5 bresp=00.
REQ-028 awsize=2 -> DRAIN accepts awlen+1 beats, no descriptors issued, bresp=10.
REQ-029 Beat 2 of 4 wstrb=0x0F..., no DMA descriptor, bresp=10 after client status.
REQ-030 awlen=255 with tready toggling every cycle -> 256 beats, tlast on beat 255 only, len=16384.
REQ-031 Host status tag=0x7 then tag=0x5 error=1 -> first ignored, bresp=10; bready held low 10 cycles -> bvalid/bid stable.
REQ-032 rst asserted in STREAM after beat 1 -> all outputs zero, awready=1 next cycle, next burst completes OKAY.
